// File: rtl/pll_lock_ctrl_pkg.sv
// Shared types and constants for the PLL reset/lock supervisor.
package pll_lock_pkg;

  // Supervisor sequence: hold PLL in reset, wait for lock, qualify lock, run.
  typedef enum logic [1:0] {
    PLLRST    = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } lock_state_t;

  // Fault counter ceiling; the counter sticks here instead of wrapping.
  localparam logic [7:0] FAULT_MAX = 8'hFF;

  // Saturating increment for the fault counter.
  function automatic logic [7:0] fault_inc(input logic [7:0] value);
    return (value == FAULT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// Status/control bundle between the lock supervisor and the PLL/core side.
interface pll_lock_ctrl_if;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_lost;
  logic       timeout;
  logic [7:0] fault_cnt;

  // Supervisor side: consumes lock, drives resets and status.
  modport master (
    input  locked,
    output pll_rst,
    output sys_rst,
    output lock_lost,
    output timeout,
    output fault_cnt
  );

  // PLL/core side: provides lock, observes resets and status.
  modport slave (
    output locked,
    input  pll_rst,
    input  sys_rst,
    input  lock_lost,
    input  timeout,
    input  fault_cnt
  );
endinterface

// File: rtl/pll_lock_ctrl_sync.sv
// Multi-flop synchronizer for a single asynchronous status bit.
// Synchronous reset clears every stage to 0.
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock, and
// holds the core in reset until lock has been stable. Retries on lock
// timeout, resequences on loss of lock, counts faults with saturation.
module pll_lock_ctrl
  import pll_lock_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = $clog2(
    (RST_CYCLES > LOCK_TIMEOUT)
      ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
      : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES)) + 1
) (
  input logic             refclk,
  input logic             rst,
  pll_lock_ctrl_if.master bus
);

  localparam logic [1:0] S_PLLRST = PLLRST;
  localparam logic [1:0] S_WAIT   = WAIT_LOCK;
  localparam logic [1:0] S_STABLE = STABLE;
  localparam logic [1:0] S_RUN    = RUN;

  // Last count value of each timed phase.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             locked_s;
  logic [1:0]       state_reg,       state_next;
  logic [CNT_W-1:0] cnt_reg,         cnt_next;
  logic             timeout_evt_reg, timeout_evt_next;
  logic             lost_evt_reg,    lost_evt_next;
  logic             pll_rst_reg;
  logic             sys_rst_reg;
  logic             lock_lost_reg;
  logic             timeout_reg;
  logic [7:0]       fault_cnt_reg;

  pll_lock_sync #(
    .STAGES (2)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.locked),
    .q   (locked_s)
  );

  // Next-state logic; the shared counter restarts on every state change.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg + 1'b1;
    timeout_evt_next = 1'b0;
    lost_evt_next    = 1'b0;
    case (state_reg)
      S_PLLRST: begin
        if (cnt_reg == RST_LAST) state_next = S_WAIT;
      end
      S_WAIT: begin
        // Lock seen in the timeout cycle still counts as a lock.
        if (locked_s) begin
          state_next = S_STABLE;
        end else if (cnt_reg == TMO_LAST) begin
          state_next       = S_PLLRST;
          timeout_evt_next = 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_next = S_WAIT;
        end else if (cnt_reg == STB_LAST) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        cnt_next = cnt_reg;  // nothing is timed in RUN; avoid wrap-around
        if (!locked_s) begin
          state_next    = S_PLLRST;
          lost_evt_next = 1'b1;
        end
      end
      default: begin
        state_next = S_PLLRST;
      end
    endcase
    if (state_next != state_reg) cnt_next = '0;
  end

  // State, counter and transition-event registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg       <= S_PLLRST;
      cnt_reg         <= '0;
      timeout_evt_reg <= 1'b0;
      lost_evt_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      timeout_evt_reg <= timeout_evt_next;
      lost_evt_reg    <= lost_evt_next;
    end
  end

  // Registered outputs decoded from the settled state, so both resets and
  // the event pulses move together and never glitch.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst_reg   <= 1'b1;
      sys_rst_reg   <= 1'b1;
      lock_lost_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      fault_cnt_reg <= 8'd0;
    end else begin
      pll_rst_reg   <= (state_reg == S_PLLRST);
      sys_rst_reg   <= (state_reg != S_RUN);
      lock_lost_reg <= lost_evt_reg;
      timeout_reg   <= timeout_evt_reg;
      if (lost_evt_reg || timeout_evt_reg) begin
        fault_cnt_reg <= fault_inc(fault_cnt_reg);
      end
    end
  end

  assign bus.pll_rst   = pll_rst_reg;
  assign bus.sys_rst   = sys_rst_reg;
  assign bus.lock_lost = lock_lost_reg;
  assign bus.timeout   = timeout_reg;
  assign bus.fault_cnt = fault_cnt_reg;

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Reset/lock supervisor that sits on the other end of the system PLL's `rst`/`locked` interface. It drives the PLL reset, waits for and qualifies `locked`, and holds the core in reset until lock has been stable for a set time. It retries the PLL on lock timeout and re-sequences on loss of lock. All logic runs on the 50 MHz `refclk`, ahead of every PLL-derived clock domain.

## Interface

Parameters:
- `RST_CYCLES`, default 16: width of the PLL reset pulse, in `refclk` cycles (≥1).
- `LOCK_TIMEOUT`, default 50000: cycles to wait for lock after PLL reset release before retrying (1 ms at 50 MHz).
- `STABLE_CYCLES`, default 1024: cycles `locked` must stay high before the core reset is released.
- `CNT_W`, default derived: counter width, `$clog2` of the largest of the three parameters above, plus 1.

Ports:
- `refclk`  in  1  50 MHz reference clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `locked`  in  1  PLL lock indication; asynchronous to `refclk`.
- `pll_rst`  out  1  reset to the PLL; active high.
- `sys_rst`  out  1  core reset; active high; low only in RUN.
- `lock_lost`  out  1  one-cycle pulse on RUN→PLLRST.
- `timeout`  out  1  one-cycle pulse on a WAIT_LOCK timeout.
- `fault_cnt`  out  8  saturating count of `lock_lost` plus `timeout` events.

## Operation

- `locked` passes through a 2-flop synchronizer to give `locked_s`. Only `locked_s` is used.
- There is one shared cycle counter, `cnt`, which is cleared on every state change.
- All outputs are registered.

States:
- PLLRST: `pll_rst`=1, `sys_rst`=1. `locked_s` is ignored. Go to WAIT_LOCK when `cnt`==RST_CYCLES-1.
- WAIT_LOCK: `pll_rst`=0, `sys_rst`=1.
  - `locked_s`=1 → STABLE.
  - Otherwise, when `cnt`==LOCK_TIMEOUT-1 → PLLRST, pulse `timeout`, increment `fault_cnt`.
  - If lock and the timeout occur in the same cycle, lock wins.
- STABLE: `sys_rst`=1.
  - `locked_s`=0 → WAIT_LOCK. The timeout restarts and `fault_cnt` does not change.
  - `cnt`==STABLE_CYCLES-1 with `locked_s`=1 → RUN.
- RUN: `sys_rst`=0, `pll_rst`=0.
  - `locked_s`=0 → PLLRST, pulse `lock_lost`, increment `fault_cnt`.

Rules:
- `fault_cnt` saturates at 255 and never wraps.
- `rst` has priority over everything, including mid-sequence. It forces state PLLRST with `cnt`=0.

Reset values:
- `pll_rst`=1, `sys_rst`=1
- `lock_lost`=0, `timeout`=0
- `fault_cnt`=0
- synchronizer flops=0

## Timing

- While `rst`=1, `pll_rst`=1. After `rst` falls, `pll_rst` stays 1 for exactly RST_CYCLES further cycles.
- `locked` to `locked_s` latency is 2 cycles. A `locked` pulse shorter than one `refclk` period may be missed; this is acceptable.
- Core reset release: if `locked` is first sampled high at edge N and stays high, `sys_rst` falls after edge N+3+STABLE_CYCLES. The 3 cycles are 2 for the synchronizer and 1 for WAIT_LOCK→STABLE.
- Loss of lock in RUN: if `locked` is first sampled low at edge M, then after edge M+3 `sys_rst`=1, `pll_rst`=1 and `lock_lost`=1. `lock_lost` is high for that cycle only.
- Timeout retry: `timeout` is high for the single cycle in which `pll_rst` re-asserts. This is LOCK_TIMEOUT cycles after `pll_rst` fell.
- `sys_rst` never glitches low outside RUN. `pll_rst` and `sys_rst`=0 are never both active.

## Structure

- Package `pll_lock_pkg`:
  - enum `lock_state_t` {PLLRST, WAIT_LOCK, STABLE, RUN}
  - constant `FAULT_MAX`=8'hFF
- Sub-module `pll_lock_sync`: a 2-flop synchronizer with synchronous reset to 0, reusable for other async status inputs.
- The top level holds the FSM, `cnt` and `fault_cnt`. The expected size is around 150 lines.

## Test plan

All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=8.

1. Clean lock: `rst` high for 3 cycles, `locked` rises 10 cycles after `pll_rst` falls → `pll_rst` high for 4 cycles after `rst` falls; `sys_rst` falls 11 cycles after `locked` is first sampled high; `fault_cnt`=0.
2. Never locks: `locked`=0 throughout → `timeout` pulses every 68 cycles; `pll_rst` re-asserts for 4 cycles each time; `fault_cnt` increments each time and saturates at 255 after 255 retries.
3. Lock loss in RUN: drop `locked` for 20 cycles → `lock_lost` pulses once, 3 cycles after the drop; full resequence follows; `fault_cnt`=1.
4. Lock bounce in STABLE: `locked` low for 2 cycles, 5 cycles into STABLE → return to WAIT_LOCK, no `timeout`, no `lock_lost`, `fault_cnt` unchanged; `sys_rst` falls 11 cycles after the second rise is sampled.
5. Reset mid-operation: assert `rst` for 1 cycle in RUN and once in WAIT_LOCK → both go to PLLRST, `sys_rst`=1 on the next edge, `fault_cnt`=0, no pulses.
6. Lock/timeout tie: `locked_s` first goes high in the cycle where `cnt`=63 → STABLE is entered and `timeout` stays 0.
